// File: rtl/bram_wr_arbiter_pkg.sv
// Shared types, default geometry and the round-robin pick function for the BRAM write arbiter.
package bram_wr_arbiter_pkg;

  localparam int unsigned AW_DEF    = 9;
  localparam int unsigned DW_DEF    = 64;
  localparam int unsigned DEPTH_DEF = 512;
  localparam int unsigned NREQ_MAX  = 4;
  localparam int unsigned PTR_W     = 2;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // First requesting index at or after ptr, wrapping at n; returns a one-hot grant.
  function automatic logic [NREQ_MAX-1:0] rr_pick(input logic [NREQ_MAX-1:0] req,
                                                  input logic [PTR_W-1:0]    ptr,
                                                  input int unsigned         n);
    logic [NREQ_MAX-1:0] g;
    logic                found;
    int unsigned         idx;
    g     = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NREQ_MAX; k++) begin
      if (k < n) begin
        idx = 32'(ptr) + k;
        if (idx >= n) idx = idx - n;
        if (!found && req[PTR_W'(idx)]) begin
          g[PTR_W'(idx)] = 1'b1;
          found          = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/bram_wr_arbiter_if.sv
// Producer-side request bus and BRAM-side write port of the shared BRAM write arbiter.
interface bram_wr_arbiter_if
  import bram_wr_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned DW   = DW_DEF
);

  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] data;
  logic [NREQ-1:0]    last;
  logic [NREQ-1:0]    gnt;
  logic               wen;
  logic [AW-1:0]      wt_address;
  logic [DW-1:0]      data_out;
  logic               busy;
  logic               err;

  modport master (
    output req, addr, data, last,
    input  gnt, wen, wt_address, data_out, busy, err
  );

  modport slave (
    input  req, addr, data, last,
    output gnt, wen, wt_address, data_out, busy, err
  );

endinterface

// File: rtl/bram_wr_rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first requester at or after ptr.
module bram_wr_rr_pick
  import bram_wr_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 3
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt
);

  logic [NREQ_MAX-1:0] pick_all;

  always_comb pick_all = rr_pick(NREQ_MAX'(req), ptr, NREQ);

  assign gnt = pick_all[NREQ-1:0];

  if (NREQ < NREQ_MAX) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^pick_all[NREQ_MAX-1:NREQ];
  end

endmodule

// File: rtl/bram_wr_arbiter.sv
// Round-robin arbiter sharing one registered BRAM write port among NREQ producers.
// Optional burst locking is enabled by defining BRAM_WR_ARB_LOCK_EN.
module bram_wr_arbiter
  import bram_wr_arbiter_pkg::*;
#(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input logic              clk,
  input logic              rst,
  bram_wr_arbiter_if.slave bus
);

  if (NREQ < 2 || NREQ > NREQ_MAX) begin : g_bad_nreq
    $error("bram_wr_arbiter: NREQ must be in 2..4");
  end

  arb_state_e       state, state_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt, sel;
  logic [NREQ-1:0]  rr_gnt, gnt_c;
  logic             accept, in_range;
  logic [AW-1:0]    addr_sel;
  logic [DW-1:0]    data_sel;
`ifdef BRAM_WR_ARB_LOCK_EN
  logic [PTR_W-1:0] owner, owner_nxt;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == NREQ - 1) ? '0 : p + PTR_W'(1);
  endfunction

  bram_wr_rr_pick #(.NREQ(NREQ)) u_pick (
    .req (bus.req),
    .ptr (ptr),
    .gnt (rr_gnt)
  );

  // Effective grant and the beat it selects
  always_comb begin
    gnt_c = rr_gnt;
`ifdef BRAM_WR_ARB_LOCK_EN
    if (state == LOCK) gnt_c = NREQ'(1) << owner;
`endif
    sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_c[i]) sel = PTR_W'(i);
    end
    accept   = |(bus.req & gnt_c);
    addr_sel = bus.addr[32'(sel)*AW +: AW];
    data_sel = bus.data[32'(sel)*DW +: DW];
    in_range = 32'(addr_sel) < DEPTH;
  end

  assign bus.gnt = gnt_c;

  // Next state, pointer and burst owner
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
`ifdef BRAM_WR_ARB_LOCK_EN
    owner_nxt = owner;
`endif
    case (state)
      ARB: begin
        if (accept) begin
`ifdef BRAM_WR_ARB_LOCK_EN
          if (!bus.last[sel]) begin
            state_nxt = LOCK;
            owner_nxt = sel;
          end else begin
            ptr_nxt = ptr_inc(sel);
          end
`else
          ptr_nxt = ptr_inc(sel);
`endif
        end
      end
`ifdef BRAM_WR_ARB_LOCK_EN
      LOCK: begin
        if (accept && bus.last[sel]) begin
          state_nxt = ARB;
          ptr_nxt   = ptr_inc(owner);
        end
      end
`endif
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB;
      ptr   <= '0;
`ifdef BRAM_WR_ARB_LOCK_EN
      owner <= '0;
`endif
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
`ifdef BRAM_WR_ARB_LOCK_EN
      owner <= owner_nxt;
`endif
    end
  end

  // Registered BRAM port; out-of-range beats are swallowed and flagged
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.wen        <= 1'b0;
      bus.wt_address <= '0;
      bus.data_out   <= '0;
      bus.err        <= 1'b0;
    end else begin
      bus.wen <= accept && in_range;
      if (accept && in_range) begin
        bus.wt_address <= addr_sel;
        bus.data_out   <= data_sel;
      end
      if (accept && !in_range) bus.err <= 1'b1;
    end
  end

`ifdef BRAM_WR_ARB_LOCK_EN
  assign bus.busy = (state == LOCK);
`else
  logic unused_last;
  assign unused_last = ^bus.last;
  assign bus.busy    = 1'b0;
`endif

endmodule

// File: tb/tb_bram_wr_arbiter.sv
// Bench for bram_wr_arbiter: rule-level reference model checked every cycle plus directed literal checks.
module tb_bram_wr_arbiter;

  localparam int unsigned NREQ  = 3;
  localparam int unsigned AW    = 9;
  localparam int unsigned DW    = 64;
  localparam int unsigned DEPTH = 480;
`ifdef BRAM_WR_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  bram_wr_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  bram_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: arbitration rules expressed with plain integers
  int          m_ptr, m_owner, cur_i;
  bit          m_lock, m_wen, m_err, m_valid;
  logic [8:0]  m_addr, cur_addr;
  logic [63:0] m_data, cur_data;
  logic [2:0]  exp_gnt;
  bit          acc_m, cur_in;

  initial m_valid = 1'b0;

  function automatic int pick(input logic [2:0] r, input int p, input bit lk, input int own);
    if (lk) return own;
    for (int k = 0; k < 3; k++) begin
      if (r[(p + k) % 3]) return (p + k) % 3;
    end
    return -1;
  endfunction

  always_comb begin
    cur_i    = pick(bus.req, m_ptr, m_lock, m_owner);
    acc_m    = 1'b0;
    cur_addr = '0;
    cur_data = '0;
    exp_gnt  = 3'b000;
    if (cur_i >= 0) begin
      acc_m    = bus.req[cur_i];
      cur_addr = bus.addr[cur_i*9 +: 9];
      cur_data = bus.data[cur_i*64 +: 64];
      exp_gnt  = 3'(3'b001 << cur_i);
    end
    cur_in = int'(cur_addr) < int'(DEPTH);
  end

  always @(posedge clk) begin
    if (rst) begin
      m_ptr <= 0; m_lock <= 1'b0; m_owner <= 0; m_wen <= 1'b0;
      m_addr <= '0; m_data <= '0; m_err <= 1'b0; m_valid <= 1'b1;
    end else begin
      m_wen <= acc_m && cur_in;
      if (acc_m && cur_in) begin
        m_addr <= cur_addr;
        m_data <= cur_data;
      end
      if (acc_m && !cur_in) m_err <= 1'b1;
      if (acc_m) begin
        if (LOCK_EN && !m_lock && !bus.last[cur_i]) begin
          m_lock  <= 1'b1;
          m_owner <= cur_i;
        end else if (LOCK_EN && m_lock) begin
          if (bus.last[cur_i]) begin
            m_lock <= 1'b0;
            m_ptr  <= (m_owner + 1) % 3;
          end
        end else begin
          m_ptr <= (cur_i + 1) % 3;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_gnt", 64'(bus.gnt), 64'(exp_gnt));
      chk("model_wen", 64'(bus.wen), 64'(m_wen));
      chk("model_wt_address", 64'(bus.wt_address), 64'(m_addr));
      chk("model_data_out", bus.data_out, m_data);
      chk("model_busy", 64'(bus.busy), 64'(m_lock));
      chk("model_err", 64'(bus.err), 64'(m_err));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int i, input logic [8:0] a, input logic [63:0] d);
    bus.addr[i*9 +: 9]   = a;
    bus.data[i*64 +: 64] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; bus.req = '0; bus.last = '0; bus.addr = '0; bus.data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_wen", 64'(bus.wen), 64'd0);
    chk("rst_wt_address", 64'(bus.wt_address), 64'd0);
    chk("rst_data_out", bus.data_out, 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_gnt", 64'(bus.gnt), 64'd0);

    // All three requesting continuously
    set_beat(0, 9'd10, 64'hA0); set_beat(1, 9'd20, 64'hA1); set_beat(2, 9'd30, 64'hA2);
    for (int c = 0; c < 6; c++) begin
      cyc();
      bus.req = 3'b111; bus.last = 3'b111;
      @(negedge clk);
      chk("rr_gnt", 64'(bus.gnt), 64'(3'(3'b001 << (c % 3))));
      if (c > 0) begin
        chk("rr_wen", 64'(bus.wen), 64'd1);
        chk("rr_wt_address", 64'(bus.wt_address), 64'(10 * ((c - 1) % 3 + 1)));
      end else begin
        chk("rr_wen_first", 64'(bus.wen), 64'd0);
      end
    end
    cyc(); bus.req = 3'b000;
    @(negedge clk);
    chk("rr_tail_wen", 64'(bus.wen), 64'd1);
    chk("rr_tail_addr", 64'(bus.wt_address), 64'd30);
    chk("rr_tail_data", bus.data_out, 64'hA2);
    cyc();
    @(negedge clk);
    chk("idle_wen", 64'(bus.wen), 64'd0);
    chk("idle_hold_addr", 64'(bus.wt_address), 64'd30);

    // Single requester 1
    cyc(); set_beat(1, 9'd47, 64'hDEAD_BEEF_0123_4567); bus.req = 3'b010;
    @(negedge clk);
    chk("single_gnt", 64'(bus.gnt), 64'h2);
    cyc(); bus.req = 3'b000;
    @(negedge clk);
    chk("single_wen", 64'(bus.wen), 64'd1);
    chk("single_addr", 64'(bus.wt_address), 64'd47);
    chk("single_data", bus.data_out, 64'hDEAD_BEEF_0123_4567);

    // Out-of-range beat and the DEPTH boundary
    cyc(); set_beat(2, 9'd511, 64'h511); bus.req = 3'b100;
    @(negedge clk);
    chk("oor_gnt", 64'(bus.gnt), 64'h4);
    chk("oor_err_before", 64'(bus.err), 64'd0);
    cyc(); bus.req = 3'b000;
    @(negedge clk);
    chk("oor_wen", 64'(bus.wen), 64'd0);
    chk("oor_err", 64'(bus.err), 64'd1);
    chk("oor_hold_addr", 64'(bus.wt_address), 64'd47);
    cyc(); set_beat(0, 9'd479, 64'h479); bus.req = 3'b001;
    @(negedge clk);
    chk("edge_gnt", 64'(bus.gnt), 64'h1);
    cyc(); set_beat(0, 9'd480, 64'h480); bus.req = 3'b001;
    @(negedge clk);
    chk("edge479_wen", 64'(bus.wen), 64'd1);
    chk("edge479_addr", 64'(bus.wt_address), 64'd479);
    cyc(); bus.req = 3'b000;
    @(negedge clk);
    chk("edge480_wen", 64'(bus.wen), 64'd0);
    chk("edge480_addr", 64'(bus.wt_address), 64'd479);
    repeat (2) begin
      cyc();
      @(negedge clk);
      chk("err_sticky", 64'(bus.err), 64'd1);
    end

`ifndef BRAM_WR_ARB_LOCK_EN
    // last is ignored: arbitration continues every beat
    for (int c = 0; c < 3; c++) begin
      cyc(); bus.req = 3'b111; bus.last = 3'b000;
      @(negedge clk);
      chk("nolock_gnt", 64'(bus.gnt), 64'(3'(3'b010 << c) | 3'(c == 2 ? 3'b001 : 3'b000)));
      chk("nolock_busy", 64'(bus.busy), 64'd0);
    end
    cyc(); bus.req = 3'b000;
`endif

    cyc(); rst = 1'b1; bus.req = 3'b000;
    cyc(); rst = 1'b0;
    @(negedge clk);
    chk("rst_clears_err", 64'(bus.err), 64'd0);

`ifdef BRAM_WR_ARB_LOCK_EN
    // 16-beat burst from requester 0 while requester 2 waits
    set_beat(2, 9'd200, 64'hC200);
    for (int k = 0; k < 16; k++) begin
      cyc();
      set_beat(0, 9'(100 + k), 64'hB000 + 64'(k));
      bus.last = (k == 15) ? 3'b101 : 3'b100;
      bus.req  = 3'b101;
      @(negedge clk);
      chk("burst_gnt", 64'(bus.gnt), 64'h1);
      chk("burst_busy", 64'(bus.busy), 64'(k > 0));
      if (k > 0) chk("burst_addr", 64'(bus.wt_address), 64'(100 + k - 1));
    end
    cyc(); bus.req = 3'b100; bus.last = 3'b100;
    @(negedge clk);
    chk("after_burst_gnt", 64'(bus.gnt), 64'h4);
    chk("after_burst_busy", 64'(bus.busy), 64'd0);
    chk("after_burst_addr", 64'(bus.wt_address), 64'd115);
    cyc(); bus.req = 3'b000; bus.last = 3'b000;
    @(negedge clk);
    chk("after_burst_r2", 64'(bus.wt_address), 64'd200);

    // Owner stalls inside its burst
    cyc(); set_beat(0, 9'd300, 64'hD300); set_beat(1, 9'd400, 64'hD400);
    bus.req = 3'b011; bus.last = 3'b000;
    @(negedge clk);
    chk("stall_first_gnt", 64'(bus.gnt), 64'h1);
    for (int j = 0; j < 3; j++) begin
      cyc(); bus.req = 3'b010;
      @(negedge clk);
      chk("stall_gnt", 64'(bus.gnt), 64'h1);
      chk("stall_busy", 64'(bus.busy), 64'd1);
      chk("stall_wen", 64'(bus.wen), 64'(j == 0));
    end
    cyc(); set_beat(0, 9'd301, 64'hD301); bus.req = 3'b011; bus.last = 3'b001;
    @(negedge clk);
    chk("stall_end_gnt", 64'(bus.gnt), 64'h1);
    chk("stall_end_wen", 64'(bus.wen), 64'd0);
    cyc(); bus.req = 3'b010; bus.last = 3'b010;
    @(negedge clk);
    chk("stall_next_gnt", 64'(bus.gnt), 64'h2);
    chk("stall_last_addr", 64'(bus.wt_address), 64'd301);
    cyc(); bus.req = 3'b000; bus.last = 3'b000;
    @(negedge clk);
    chk("stall_r1_addr", 64'(bus.wt_address), 64'd400);
`endif

    // Reset arriving on the fifth beat of a stream from requester 0
    for (int b = 0; b < 5; b++) begin
      cyc();
      set_beat(0, 9'(50 + b), 64'hE000 + 64'(b));
      bus.req = 3'b001; bus.last = 3'b000;
      rst = (b == 4);
      @(negedge clk);
      chk("mid_gnt", 64'(bus.gnt), 64'h1);
    end
    cyc(); rst = 1'b0; set_beat(1, 9'd60, 64'hF060); bus.req = 3'b110; bus.last = 3'b110;
    @(negedge clk);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_wen", 64'(bus.wen), 64'd0);
    chk("midrst_gnt", 64'(bus.gnt), 64'h2);
    cyc(); bus.req = 3'b000; bus.last = 3'b000;
    @(negedge clk);
    chk("midrst_r1_addr", 64'(bus.wt_address), 64'd60);
    chk("midrst_r1_wen", 64'(bus.wen), 64'd1);

    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
